// File: rtl/eth_mac_pkg.sv
// Shared Ethernet MAC definitions: XGMII control codes, frame delimiters, CRC-32 constants,
// the RX MAC state enum and the AXI-stream beat payload.
package eth_mac_pkg;

    localparam int unsigned CNT_W = 16;

    localparam logic [7:0]  XGMII_START   = 8'hFB;
    localparam logic [7:0]  XGMII_TERM    = 8'hFD;
    localparam logic [7:0]  XGMII_IDLE    = 8'h07;
    localparam logic [7:0]  XGMII_ERROR   = 8'hFE;
    localparam logic [7:0]  ETH_HDR       = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        DATA,
        LAST,
        DROP
    } rx_state_t;

    typedef struct packed {
        logic [31:0] tdata;
        logic [3:0]  tkeep;
        logic        tlast;
        logic        tuser;
    } axis_beat_t;

    // Byte counter add that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [2:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W+1)'(b);
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/crc32_d32.sv
// Combinational reflected CRC-32 step over up to four bytes, lane0 first; lanes with keep=0 are skipped.
module crc32_d32
    import eth_mac_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  keep_i,
    output logic [31:0] crc_o
);

    logic [31:0] crc_c;

    always_comb begin
        crc_c = crc_i;
        for (int b = 0; b < 4; b++) begin
            if (keep_i[b]) begin
                for (int i = 0; i < 8; i++) begin
                    crc_c = (crc_c >> 1) ^ (CRC32_POLY & {32{crc_c[0] ^ data_i[8*b+i]}});
                end
            end
        end
        crc_o = crc_c;
    end

endmodule

// File: rtl/rx_mac.sv
// Receive MAC: XGMII start/preamble/SFD detection, frame forwarding to AXI-stream with byte enables,
// length/XGMII error flagging on tlast. Optional FCS check under `RX_MAC_CRC_CHECK_EN`.
module rx_mac
    import eth_mac_pkg::*;
#(
    parameter int unsigned XGMII_DATA_WIDTH = 32,
    parameter int unsigned XGMII_CTRL_WIDTH = 4,
    parameter int unsigned MIN_FRAME_BYTES  = 64,
    parameter int unsigned MAX_FRAME_BYTES  = 1518
) (
    input  logic                        i_clk,
    input  logic                        i_resent_n,
    input  logic [XGMII_DATA_WIDTH-1:0] i_xgmii_rxd,
    input  logic [XGMII_CTRL_WIDTH-1:0] i_xgmii_ctrl,
    input  logic                        i_xgmii_valid,
    output logic [XGMII_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [XGMII_CTRL_WIDTH-1:0] m_axis_tkeep,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast,
    output logic                        m_axis_tuser
);

    rx_state_t        state_q, state_d;
    logic [31:0]      hold_q, hold_d;
    logic [3:0]       keep_q, keep_d;
    logic             hold_vld_q, hold_vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    axis_beat_t       beat_q, beat_d;

    logic [1:0]  low_lane_c;
    logic        term_c;
    logic [3:0]  term_keep_c;
    logic [31:0] term_data_c;
    logic        start_c;
    logic        start_ok_c;
    logic        sfd_ok_c;
    logic        idle_c;
    logic        len_err_c;
    logic        crc_bad_c;

    // Word classification; the lowest lane carrying a control bit decides what a control word is.
    always_comb begin
        low_lane_c  = 2'd0;
        term_keep_c = 4'b0000;
        term_data_c = 32'h0;
        for (int l = 3; l >= 0; l--) begin
            if (i_xgmii_ctrl[l]) low_lane_c = 2'(l);
        end
        term_c = (|i_xgmii_ctrl) && (i_xgmii_rxd[8*low_lane_c +: 8] == XGMII_TERM);
        for (int l = 0; l < 4; l++) begin
            if (2'(l) < low_lane_c) begin
                term_keep_c[l]        = 1'b1;
                term_data_c[8*l +: 8] = i_xgmii_rxd[8*l +: 8];
            end
        end
        start_c    = (i_xgmii_ctrl == 4'b0001) && (i_xgmii_rxd[7:0] == XGMII_START);
        start_ok_c = start_c && (i_xgmii_rxd[31:8] == {3{ETH_HDR}});
        sfd_ok_c   = (i_xgmii_ctrl == 4'b0000) && (i_xgmii_rxd == {ETH_SFD, {3{ETH_HDR}}});
        idle_c     = (i_xgmii_ctrl == 4'b1111) && (i_xgmii_rxd == {4{XGMII_IDLE}});
    end

    assign len_err_c = (cnt_q < CNT_W'(MIN_FRAME_BYTES)) || (cnt_q > CNT_W'(MAX_FRAME_BYTES));

`ifdef RX_MAC_CRC_CHECK_EN
    logic [31:0] crc_q, crc_d, crc_step_c;
    logic [3:0]  crc_keep_c;

    assign crc_keep_c = term_c ? term_keep_c : 4'hF;

    crc32_d32 u_crc (
        .crc_i  (crc_q),
        .data_i (i_xgmii_rxd),
        .keep_i (crc_keep_c),
        .crc_o  (crc_step_c)
    );

    // CRC follows the bytes loaded into the hold register, so at tlast it already covers the FCS.
    always_comb begin
        crc_d = crc_q;
        if (i_xgmii_valid && state_q == PREAMBLE && sfd_ok_c) begin
            crc_d = 32'hFFFF_FFFF;
        end else if (i_xgmii_valid && state_q == DATA &&
                     (i_xgmii_ctrl == 4'b0000 || (term_c && low_lane_c != 2'd0))) begin
            crc_d = crc_step_c;
        end
    end

    always_ff @(posedge i_clk or negedge i_resent_n) begin
        if (!i_resent_n) crc_q <= 32'hFFFF_FFFF;
        else             crc_q <= crc_d;
    end

    assign crc_bad_c = (crc_q != CRC32_RESIDUE);
`else
    assign crc_bad_c = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        keep_d     = keep_q;
        hold_vld_d = hold_vld_q;
        cnt_d      = cnt_q;
        beat_d     = '0;

        case (state_q)
            IDLE: begin
                if (i_xgmii_valid) begin
                    if (start_ok_c)   state_d = PREAMBLE;
                    else if (start_c) state_d = DROP;
                end
            end

            PREAMBLE: begin
                if (i_xgmii_valid) begin
                    if (sfd_ok_c) begin
                        state_d    = DATA;
                        cnt_d      = '0;
                        hold_vld_d = 1'b0;
                    end else begin
                        state_d = DROP;
                    end
                end
            end

            DATA: begin
                if (i_xgmii_valid) begin
                    if (i_xgmii_ctrl == 4'b0000) begin
                        if (hold_vld_q) beat_d = '{tdata: hold_q, tkeep: keep_q, tlast: 1'b0, tuser: 1'b0};
                        hold_d     = i_xgmii_rxd;
                        keep_d     = 4'hF;
                        hold_vld_d = 1'b1;
                        cnt_d      = sat_add(cnt_q, 3'd4);
                    end else if (term_c && low_lane_c == 2'd0) begin
                        if (hold_vld_q) beat_d = '{tdata: hold_q, tkeep: keep_q, tlast: 1'b1,
                                                   tuser: len_err_c | crc_bad_c};
                        hold_vld_d = 1'b0;
                        state_d    = IDLE;
                    end else if (term_c) begin
                        if (hold_vld_q) beat_d = '{tdata: hold_q, tkeep: keep_q, tlast: 1'b0, tuser: 1'b0};
                        hold_d     = term_data_c;
                        keep_d     = term_keep_c;
                        hold_vld_d = 1'b1;
                        cnt_d      = sat_add(cnt_q, 3'(low_lane_c));
                        state_d    = LAST;
                    end else begin
                        // Error or unexpected control: close what was held as a bad frame.
                        if (hold_vld_q) beat_d = '{tdata: hold_q, tkeep: keep_q, tlast: 1'b1, tuser: 1'b1};
                        hold_vld_d = 1'b0;
                        state_d    = start_ok_c ? PREAMBLE : DROP;
                    end
                end
            end

            LAST: begin
                beat_d     = '{tdata: hold_q, tkeep: keep_q, tlast: 1'b1, tuser: len_err_c | crc_bad_c};
                hold_vld_d = 1'b0;
                state_d    = IDLE;
            end

            DROP: begin
                if (i_xgmii_valid && (term_c || idle_c)) state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_resent_n) begin
        if (!i_resent_n) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            keep_q     <= '0;
            hold_vld_q <= 1'b0;
            cnt_q      <= '0;
            beat_q     <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            keep_q     <= keep_d;
            hold_vld_q <= hold_vld_d;
            cnt_q      <= cnt_d;
            beat_q     <= beat_d;
        end
    end

    assign m_axis_tdata  = beat_q.tdata;
    assign m_axis_tkeep  = beat_q.tkeep;
    assign m_axis_tvalid = beat_q.tkeep != 4'b0000;
    assign m_axis_tlast  = beat_q.tlast;
    assign m_axis_tuser  = beat_q.tuser;

endmodule

// File: tb/tb_rx_mac.sv
// Scenario bench for rx_mac: random-payload frames with valid FCS, checked against a byte-level frame model.
module tb_rx_mac;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] rxd = 32'h07070707;
    logic [3:0]  ctrl = 4'hF;
    logic        valid = 1'b0;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tvalid, tlast, tuser;

`ifdef RX_MAC_CRC_CHECK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    typedef struct packed {logic [31:0] data; logic [3:0] keep; logic last; logic user;} beat_t;
    typedef struct packed {logic [31:0] d; logic [3:0] c; logic v;} xw_t;

    beat_t      got_q[$];
    beat_t      exp_q[$];
    int         got_cyc[$];
    xw_t        wq[$];
    logic [7:0] frame_q[$];
    int errors = 0, checks = 0, cyc = 0, junk = 0;

    rx_mac dut (
        .i_clk         (clk),
        .i_resent_n    (rst_n),
        .i_xgmii_rxd   (rxd),
        .i_xgmii_ctrl  (ctrl),
        .i_xgmii_valid (valid),
        .m_axis_tdata  (tdata),
        .m_axis_tkeep  (tkeep),
        .m_axis_tvalid (tvalid),
        .m_axis_tlast  (tlast),
        .m_axis_tuser  (tuser)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tvalid) begin
            got_q.push_back('{data: tdata, keep: tkeep, last: tlast, user: tuser});
            got_cyc.push_back(cyc);
        end else if ({tdata, tkeep, tlast, tuser} !== '0) begin
            junk++;
        end
    end

    task automatic drive_word(input xw_t w);
        @(negedge clk);
        rxd = w.d; ctrl = w.c; valid = w.v;
    endtask

    task automatic send_wq(output int t_first);
        t_first = -1;
        for (int i = 0; i < wq.size(); i++) begin
            drive_word(wq[i]);
            if (i == 2) t_first = cyc;
        end
    endtask

    task automatic flush();
        got_q.delete(); got_cyc.delete(); exp_q.delete();
    endtask

    function automatic logic [31:0] fcs_of(input int n);
        logic [31:0] c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c ^= {24'h0, frame_q[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    // Frame of len bytes (DA..FCS) with a correct FCS; optionally one payload bit flipped afterwards.
    task automatic make_frame(input int len, input bit flip);
        logic [31:0] f;
        frame_q.delete();
        for (int i = 0; i < len - 4; i++) frame_q.push_back(8'($urandom));
        f = fcs_of(len - 4);
        for (int i = 0; i < 4; i++) frame_q.push_back(f[8*i +: 8]);
        if (flip) frame_q[5] = frame_q[5] ^ 8'h10;
    endtask

    task automatic build_words();
        int n = frame_q.size();
        int r = n % 4;
        logic [31:0] d;
        logic [3:0]  c;
        wq.delete();
        wq.push_back('{d: 32'h555555FB, c: 4'h1, v: 1'b1});
        wq.push_back('{d: 32'hD5555555, c: 4'h0, v: 1'b1});
        for (int w = 0; w < n / 4; w++)
            wq.push_back('{d: {frame_q[4*w+3], frame_q[4*w+2], frame_q[4*w+1], frame_q[4*w]}, c: 4'h0, v: 1'b1});
        d = 32'h07070707; c = 4'h0;
        for (int l = 0; l < 4; l++) begin
            if (l < r) d[8*l +: 8] = frame_q[n - r + l];
            else c[l] = 1'b1;
            if (l == r) d[8*l +: 8] = 8'hFD;
        end
        wq.push_back('{d: d, c: c, v: 1'b1});
        wq.push_back('{d: 32'h07070707, c: 4'hF, v: 1'b1});
    endtask

    function automatic bit frame_err(input int n, input bit flipped);
        return (n < 64) || (n > 1518) || (CRC_EN && flipped);
    endfunction

    task automatic model_frame(input bit err);
        int n = frame_q.size();
        for (int b = 0; b < n; b += 4) begin
            beat_t e;
            e = '0;
            for (int l = 0; l < 4; l++)
                if (b + l < n) begin e.data[8*l +: 8] = frame_q[b+l]; e.keep[l] = 1'b1; end
            e.last = (b + 4 >= n);
            e.user = e.last && err;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input int n);
        for (int i = 0; i < 400 && got_q.size() < n; i++) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tdata, tkeep, tvalid, tlast, tuser} !== '0) begin
            errors++; $display("FAIL reset_hold: got %h want 0", {tdata, tkeep, tvalid, tlast, tuser});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({tdata, tkeep, tvalid, tlast, tuser} !== '0 || got_q.size() != 0) begin
            errors++; $display("FAIL reset_release: got %h beats %0d want 0", {tdata, tkeep, tvalid, tlast, tuser}, got_q.size());
        end
    endtask

    task automatic test_min_frame();
        int t0;
        flush(); make_frame(64, 1'b0); build_words(); model_frame(frame_err(64, 1'b0));
        send_wq(t0); wait_drain(exp_q.size());
        checks++;
        if (got_q.size() != 16) begin errors++; $display("FAIL min_frame count: got %0d want 16", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL min_frame beat %0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        checks++;
        if (got_cyc.size() == 0 || got_cyc[0] - t0 != 2) begin
            errors++; $display("FAIL min_frame latency: got %0d want 2", got_cyc.size() ? got_cyc[0] - t0 : -1);
        end
    endtask

    task automatic test_odd_frame();
        int t0;
        flush(); make_frame(65, 1'b0); build_words(); model_frame(frame_err(65, 1'b0));
        send_wq(t0); wait_drain(exp_q.size());
        checks++;
        if (got_q.size() != 17) begin errors++; $display("FAIL odd_frame count: got %0d want 17", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL odd_frame beat %0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        checks++;
        if (got_q.size() < 17 || got_q[16].keep !== 4'b0001 || got_cyc[16] - got_cyc[15] != 1) begin
            errors++; $display("FAIL odd_frame last_beat: got beats %0d want keep 0001 one cycle after beat 16", got_q.size());
        end
    endtask

    task automatic test_lengths();
        int lens[8] = '{40, 63, 64, 66, 67, 1518, 1519, 0};
        int t0;
        lens[7] = $urandom_range(68, 300);
        foreach (lens[j]) begin
            flush(); make_frame(lens[j], 1'b0); build_words(); model_frame(frame_err(lens[j], 1'b0));
            send_wq(t0); wait_drain(exp_q.size());
            checks++;
            if (got_q.size() != exp_q.size()) begin
                errors++; $display("FAIL len%0d count: got %0d want %0d", lens[j], got_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL len%0d beat %0d: got %h want %h", lens[j], i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_no_sfd();
        int t0;
        flush(); make_frame(64, 1'b0); build_words();
        wq[1].d = 32'h55555555;
        send_wq(t0); wait_drain(1);
        checks++;
        if (got_q.size() != 0) begin errors++; $display("FAIL no_sfd beats: got %0d want 0", got_q.size()); end
        flush(); make_frame(72, 1'b0); build_words(); model_frame(frame_err(72, 1'b0));
        send_wq(t0); wait_drain(exp_q.size());
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL after_no_sfd count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL after_no_sfd beat %0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_xgmii_error();
        int t0;
        flush(); make_frame(64, 1'b0); build_words();
        wq[6].c = 4'b0100;
        wq[6].d[23:16] = 8'hFE;
        for (int b = 0; b < 4; b++) begin
            exp_q.push_back('{data: {frame_q[4*b+3], frame_q[4*b+2], frame_q[4*b+1], frame_q[4*b]},
                              keep: 4'hF, last: (b == 3), user: (b == 3)});
        end
        send_wq(t0); wait_drain(exp_q.size());
        checks++;
        if (got_q.size() != 4) begin errors++; $display("FAIL xgmii_err count: got %0d want 4", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL xgmii_err beat %0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_pause();
        int t0;
        flush(); make_frame(72, 1'b0); build_words(); model_frame(frame_err(72, 1'b0));
        for (int p = 0; p < 3; p++) wq.insert(7, '{d: $urandom, c: 4'($urandom), v: 1'b0});
        send_wq(t0); wait_drain(exp_q.size());
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL pause count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL pause beat %0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_crc_flip();
        int t0;
        flush(); make_frame(64, 1'b1); build_words(); model_frame(frame_err(64, 1'b1));
        send_wq(t0); wait_drain(exp_q.size());
        checks++;
        if (got_q.size() != 16 || got_q[15].user !== CRC_EN) begin
            errors++; $display("FAIL crc_flip tuser: got beats %0d want 16 with tuser %0d", got_q.size(), CRC_EN);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL crc_flip beat %0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        xw_t tmp[$];
        int  t0;
        flush(); make_frame(68, 1'b0); build_words(); model_frame(frame_err(68, 1'b0));
        void'(wq.pop_back());
        tmp = wq;
        make_frame($urandom_range(60, 100), 1'b0); build_words(); model_frame(frame_err(frame_q.size(), 1'b0));
        wq = {tmp, wq};
        send_wq(t0); wait_drain(exp_q.size());
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b beat %0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int t0;
        flush(); make_frame(64, 1'b0); build_words();
        for (int i = 0; i < 8; i++) drive_word(wq[i]);
        @(negedge clk);
        checks++;
        if (tvalid !== 1'b1) begin errors++; $display("FAIL pre_reset_beat: got tvalid %b want 1", tvalid); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({tdata, tkeep, tvalid, tlast, tuser} !== '0) begin
            errors++; $display("FAIL reset_async: got %h want 0", {tdata, tkeep, tvalid, tlast, tuser});
        end
        rxd = 32'h07070707; ctrl = 4'hF; valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        flush(); make_frame($urandom_range(64, 120), 1'b0); build_words(); model_frame(frame_err(frame_q.size(), 1'b0));
        send_wq(t0); wait_drain(exp_q.size());
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL post_reset count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL post_reset beat %0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_min_frame();
        test_odd_frame();
        test_lengths();
        test_no_sfd();
        test_xgmii_error();
        test_pause();
        test_crc_flip();
        test_back_to_back();
        test_reset_mid_frame();
        checks++;
        if (junk != 0) begin errors++; $display("FAIL idle_outputs: got %0d nonzero idle cycles want 0", junk); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_mac.md
Name: rx_mac

Overview:
- Receive-side MAC: the counterpart of the TX MAC.
- Accepts 32-bit XGMII words from the PCS and detects start, preamble and SFD.
- Forwards frame bytes, FCS included, as an AXI-stream with byte enables.
- Flags runt, oversize and XGMII-error frames on the last beat; downstream is an RX FIFO that never stalls.

Parameters:
- XGMII_DATA_WIDTH, 32, XGMII/AXI data width; only 32 supported.
- XGMII_CTRL_WIDTH, 4, one control bit per lane.
- MIN_FRAME_BYTES, 64, frames shorter than this (DA through FCS) are flagged.
- MAX_FRAME_BYTES, 1518, frames longer than this are flagged.

Ports:
- i_clk  in  1  clock.
- i_resent_n  in  1  reset; asynchronous, active-low.
- i_xgmii_rxd  in  32  XGMII data, lane0 = bits[7:0].
- i_xgmii_ctrl  in  4  XGMII control, bit k marks lane k.
- i_xgmii_valid  in  1  word qualifier; low = gearbox pause, word ignored.
- m_axis_tdata  out  32  frame bytes, byte0 = bits[7:0].
- m_axis_tkeep  out  4  byte enables, contiguous from lane0.
- m_axis_tvalid  out  1  beat valid; no tready, sink must accept every beat.
- m_axis_tlast  out  1  last beat of frame.
- m_axis_tuser  out  1  frame error; meaningful only with tlast.

Behaviour:
- Reset: asynchronous assert, synchronous release. All m_axis outputs are 0, state is IDLE, the hold register is empty and the byte counter is 0.
- Term word: any word with a set ctrl bit whose lowest set lane holds 0xFD. Lane k = lowest 0xFD lane.
- Only cycles with i_xgmii_valid=1 advance IDLE/PREAMBLE/DATA/DROP.
- IDLE: waits for ctrl=0001 with rxd=0x555555FB, then goes to PREAMBLE. A start pattern with wrong preamble bytes goes to DROP.
- PREAMBLE: expects ctrl=0000 and rxd=0xD5555555, then goes to DATA with the counter cleared. Anything else goes to DROP with no output.
- DATA: each word lands in a one-word hold register. The previous held word is emitted as a full beat (tkeep=1111, tlast=0) when the next data word is sampled.
  - Term in lane0: the held word is emitted with tlast=1; go to IDLE.
  - Term in lane k>0: the held word is emitted (tlast=0); bytes 0..k-1 become held with tkeep=(1<<k)-1; go to LAST.
  - Any other ctrl byte (e.g. 0xFE) or a new start: the held word is emitted with tlast=1, tuser=1. Go to DROP, or to PREAMBLE if the byte was a start.
- LAST: the held partial beat is emitted with tlast=1 on the next cycle regardless of i_xgmii_valid; go to IDLE.
- DROP: discards words until a term or an all-idle (ctrl=1111, 0x07) word, then goes to IDLE.
- Data word, then term in lane0, with nothing held (empty frame): no beat is output; go to IDLE.
- Byte counter: 16-bit, saturating, counts bytes loaded into the hold register.
  - tuser=1 on tlast if count < MIN_FRAME_BYTES or count > MAX_FRAME_BYTES.
  - Overlong frames keep streaming.
- Latency: word N (full) appears on m_axis the cycle after word N+1 is sampled. With back-to-back valid words this is 2 cycles.
- m_axis_tvalid is a single-cycle pulse per beat; tdata/tkeep/tlast/tuser are 0 when tvalid=0.
- Start in lane0 is the only start position recognised.

Optional Feature:
- Macro: RX_MAC_CRC_CHECK_EN.
- When defined:
  - A CRC-32 (802.3, reflected, init 0xFFFFFFFF) runs over all forwarded bytes, FCS included, respecting tkeep.
  - At tlast, a residue other than 0xDEBB20E3 ORs 1 into tuser.
  - The CRC is reset at SFD.
- When undefined: no CRC logic; tuser covers only length and XGMII errors.

Decomposition:
- Shared package eth_mac_pkg: XGMII_START 0xFB, XGMII_TERM 0xFD, XGMII_IDLE 0x07, XGMII_ERROR 0xFE, ETH_HDR 0x55, ETH_SFD 0xD5, CRC32_POLY 0xEDB88320, CRC32_RESIDUE 0xDEBB20E3, and the rx_state_t enum {IDLE, PREAMBLE, DATA, LAST, DROP}.
- Sub-module: crc32_d32, combinational 32-bit-input CRC step with byte-enable, shared later with the TX MAC CRC append.

Test Plan:
- 64-byte frame (16 data words), term at lane0 of word 17 -> 16 beats, tkeep=1111 throughout, tlast on beat 16, tuser=0. First beat appears 2 cycles after the first data word.
- 65-byte frame, term in lane1 -> 17 beats; last beat tkeep=0001, tlast=1, tuser=0; the LAST-state beat arrives one cycle after beat 16.
- 40-byte runt -> 10 beats, tlast with tuser=1.
- Second word 0x55555555 (no SFD) -> no beats; the next valid frame is received correctly.
- 0xFE in lane2 of data word 5 -> beat 4 carries tlast=1, tuser=1; the rest of the frame is dropped until term.
- i_xgmii_valid low for 3 cycles mid-frame -> no beats or duplicates during the pause; byte order is preserved.
- With RX_MAC_CRC_CHECK_EN: a correct-FCS 64-byte frame gives tuser=0; the same frame with one payload bit flipped gives tuser=1.
- Reset asserted mid-frame -> outputs go to 0 immediately, and a following frame is received cleanly.
